// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants and helpers for the round-robin system bus
package bus_pkg;

   // Read data returned alongside a decode-error response.
   localparam logic [63:0] BusErrRdata = '0;

   // Index width for n items: $clog2(n), never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_rr_arb.sv
// rtl/bus_rr_arb.sv - round-robin arbiter, pointer advances past each winner
module bus_rr_arb
   import bus_pkg::*;
#(
   parameter  int unsigned NrHosts = 2,
   localparam int unsigned IdxW    = idx_width(NrHosts)
) (
   input  logic               clk_sys_i,
   input  logic               rst_sys_ni,
   input  logic [NrHosts-1:0] req_i,
   output logic [NrHosts-1:0] gnt_o,
   output logic [IdxW-1:0]    idx_o,
   output logic               valid_o
);

   logic [IdxW-1:0] ptr_q;

   // Pick the first requester at or after the pointer, wrapping around.
   always_comb begin
      logic [IdxW-1:0] cand;
      valid_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int unsigned off = 0; off < NrHosts; off++) begin
         cand = IdxW'((32'(ptr_q) + off) % NrHosts);
         if (!valid_o && req_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

   // One-hot grant for the winner.
   always_comb begin
      gnt_o = '0;
      if (valid_o) gnt_o[idx_o] = 1'b1;
   end

   // Move the pointer just past the winner; hold it when nothing is granted.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         ptr_q <= '0;
      end else if (valid_o) begin
         ptr_q <= (idx_o == IdxW'(NrHosts - 1)) ? '0 : idx_o + IdxW'(1);
      end
   end

endmodule

// File: rtl/bus_rr_pipelined.sv
// rtl/bus_rr_pipelined.sv - multi-host bus with round-robin grant and in-order responses
module bus_rr_pipelined
   import bus_pkg::*;
#(
   parameter int unsigned NrHosts        = 2,
   parameter int unsigned NrDevices      = 8,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned AddressWidth   = 32,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                    clk_sys_i,
   input  logic                    rst_sys_ni,

   input  logic [NrHosts-1:0]      host_req_i,
   output logic [NrHosts-1:0]      host_gnt_o,
   input  logic [AddressWidth-1:0] host_addr_i    [NrHosts],
   input  logic [NrHosts-1:0]      host_we_i,
   input  logic [DataWidth/8-1:0]  host_be_i      [NrHosts],
   input  logic [DataWidth-1:0]    host_wdata_i   [NrHosts],
   output logic [NrHosts-1:0]      host_rvalid_o,
   output logic [DataWidth-1:0]    host_rdata_o   [NrHosts],
   output logic [NrHosts-1:0]      host_err_o,

   output logic [NrDevices-1:0]    device_req_o,
   output logic [AddressWidth-1:0] device_addr_o  [NrDevices],
   output logic [NrDevices-1:0]    device_we_o,
   output logic [DataWidth/8-1:0]  device_be_o    [NrDevices],
   output logic [DataWidth-1:0]    device_wdata_o [NrDevices],
   input  logic [NrDevices-1:0]    device_rvalid_i,
   input  logic [DataWidth-1:0]    device_rdata_i [NrDevices],
   input  logic [NrDevices-1:0]    device_err_i,

   input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
   input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

   localparam int unsigned HostIdxW = idx_width(NrHosts);
   localparam int unsigned DevIdxW  = idx_width(NrDevices);
   localparam int unsigned QIdxW    = idx_width(MaxOutstanding);
   localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);

   // Tracking queue: one entry per granted transaction, oldest at rd_ptr_q.
   logic [CntW-1:0]     cnt_q;
   logic [QIdxW-1:0]    rd_ptr_q;
   logic [QIdxW-1:0]    wr_ptr_q;
   logic [HostIdxW-1:0] q_host_q [MaxOutstanding];
   logic [DevIdxW-1:0]  q_dev_q  [MaxOutstanding];
   logic [MaxOutstanding-1:0] q_miss_q;

   logic                can_accept;
   logic [NrHosts-1:0]  arb_req;
   logic [HostIdxW-1:0] win_idx;
   logic                win_valid;
   logic                dec_hit;
   logic [DevIdxW-1:0]  dec_idx;
   logic                push;
   logic                pop;
   logic [HostIdxW-1:0] head_host;
   logic [DevIdxW-1:0]  head_dev;
   logic                head_miss;
   logic [NrDevices-1:0] head_expect;

   function automatic logic [QIdxW-1:0] q_next(input logic [QIdxW-1:0] p);
      return (p == QIdxW'(MaxOutstanding - 1)) ? '0 : p + QIdxW'(1);
   endfunction

   // Eligibility uses only the registered count, so a same-cycle response never feeds gnt.
   assign can_accept = rst_sys_ni && (cnt_q < CntW'(MaxOutstanding));
   assign arb_req    = host_req_i & {NrHosts{can_accept}};

   bus_rr_arb #(
      .NrHosts (NrHosts)
   ) u_arb (
      .clk_sys_i  (clk_sys_i),
      .rst_sys_ni (rst_sys_ni),
      .req_i      (arb_req),
      .gnt_o      (host_gnt_o),
      .idx_o      (win_idx),
      .valid_o    (win_valid)
   );

   // Address decode of the winning host; the lowest-index matching device wins.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int d = int'(NrDevices) - 1; d >= 0; d--) begin
         if ((host_addr_i[win_idx] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
            dec_hit = 1'b1;
            dec_idx = DevIdxW'(d);
         end
      end
   end

   // Grant is acceptance: the decoded device sees the request in the same cycle.
   always_comb begin
      for (int d = 0; d < int'(NrDevices); d++) begin
         device_req_o[d]   = win_valid && dec_hit && (dec_idx == DevIdxW'(d));
         device_addr_o[d]  = host_addr_i[win_idx];
         device_we_o[d]    = host_we_i[win_idx];
         device_be_o[d]    = host_be_i[win_idx];
         device_wdata_o[d] = host_wdata_i[win_idx];
      end
   end

   assign push      = win_valid;
   assign head_host = q_host_q[rd_ptr_q];
   assign head_dev  = q_dev_q[rd_ptr_q];
   assign head_miss = q_miss_q[rd_ptr_q];

   // The head retires on its device's response, or immediately if it missed decode.
   assign pop = (cnt_q != '0) && (head_miss || device_rvalid_i[head_dev]);

   // Queue pointers and occupancy; reset flushes anything still in flight.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         cnt_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= q_next(wr_ptr_q);
         if (pop)  rd_ptr_q <= q_next(rd_ptr_q);
         if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
         else if (pop && !push) cnt_q <= cnt_q - CntW'(1);
      end
   end

   // Queue payload; only meaningful between push and pop, so it needs no reset.
   always_ff @(posedge clk_sys_i) begin
      if (push) begin
         q_host_q[wr_ptr_q] <= win_idx;
         q_dev_q[wr_ptr_q]  <= dec_idx;
         q_miss_q[wr_ptr_q] <= !dec_hit;
      end
   end

   // Registered response to the head's host; rdata is zero whenever rvalid is low.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         host_rvalid_o <= '0;
         host_err_o    <= '0;
         for (int h = 0; h < int'(NrHosts); h++) host_rdata_o[h] <= '0;
      end else begin
         for (int h = 0; h < int'(NrHosts); h++) begin
            host_rvalid_o[h] <= pop && (head_host == HostIdxW'(h));
            host_err_o[h]    <= pop && (head_host == HostIdxW'(h)) &&
                                (head_miss || device_err_i[head_dev]);
            if (!(pop && (head_host == HostIdxW'(h))))
               host_rdata_o[h] <= '0;
            else if (head_miss)
               host_rdata_o[h] <= BusErrRdata[DataWidth-1:0];
            else
               host_rdata_o[h] <= device_rdata_i[head_dev];
         end
      end
   end

   // Only the head's device may respond; anything else is dropped and flagged.
   always_comb begin
      head_expect = '0;
      if ((cnt_q != '0) && !head_miss) head_expect[head_dev] = 1'b1;
   end

   stray_rvalid_a : assert property (@(posedge clk_sys_i) disable iff (!rst_sys_ni)
      (device_rvalid_i & ~head_expect) == '0)
      else $warning("bus_rr_pipelined: dropped unexpected device response %b", device_rvalid_i);

endmodule

// File: tb/tb_bus_rr_pipelined.sv
// tb/tb_bus_rr_pipelined.sv - directed self-checking bench for bus_rr_pipelined
module tb_bus_rr_pipelined;

   localparam int NrHosts   = 2;
   localparam int NrDevices = 8;

   logic        clk_sys_i  = 1'b0;
   logic        rst_sys_ni = 1'b1;
   logic [1:0]  host_req_i;
   logic [1:0]  host_gnt_o;
   logic [31:0] host_addr_i  [NrHosts];
   logic [1:0]  host_we_i;
   logic [3:0]  host_be_i    [NrHosts];
   logic [31:0] host_wdata_i [NrHosts];
   logic [1:0]  host_rvalid_o;
   logic [31:0] host_rdata_o [NrHosts];
   logic [1:0]  host_err_o;
   logic [7:0]  device_req_o;
   logic [31:0] device_addr_o  [NrDevices];
   logic [7:0]  device_we_o;
   logic [3:0]  device_be_o    [NrDevices];
   logic [31:0] device_wdata_o [NrDevices];
   logic [7:0]  device_rvalid_i;
   logic [31:0] device_rdata_i [NrDevices];
   logic [7:0]  device_err_i;
   logic [31:0] cfg_device_addr_base [NrDevices];
   logic [31:0] cfg_device_addr_mask [NrDevices];

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      int          dev;
      int          due;
      logic [31:0] data;
      logic        err;
   } resp_t;

   resp_t       pend[$];
   int          cyc;
   int          dev_lat  [NrDevices];
   logic [31:0] dev_data [NrDevices];
   logic        dev_err  [NrDevices];

   bus_rr_pipelined dut (
      .clk_sys_i            (clk_sys_i),
      .rst_sys_ni           (rst_sys_ni),
      .host_req_i           (host_req_i),
      .host_gnt_o           (host_gnt_o),
      .host_addr_i          (host_addr_i),
      .host_we_i            (host_we_i),
      .host_be_i            (host_be_i),
      .host_wdata_i         (host_wdata_i),
      .host_rvalid_o        (host_rvalid_o),
      .host_rdata_o         (host_rdata_o),
      .host_err_o           (host_err_o),
      .device_req_o         (device_req_o),
      .device_addr_o        (device_addr_o),
      .device_we_o          (device_we_o),
      .device_be_o          (device_be_o),
      .device_wdata_o       (device_wdata_o),
      .device_rvalid_i      (device_rvalid_i),
      .device_rdata_i       (device_rdata_i),
      .device_err_i         (device_err_i),
      .cfg_device_addr_base (cfg_device_addr_base),
      .cfg_device_addr_mask (cfg_device_addr_mask)
   );

   always #5 clk_sys_i = ~clk_sys_i;

   // Device model: a request in cycle c answers in cycle c + dev_lat, data = dev_data + addr[3:2].
   initial begin
      cyc             = 0;
      device_rvalid_i = '0;
      device_err_i    = '0;
      for (int d = 0; d < NrDevices; d++) device_rdata_i[d] = '0;
      forever begin
         @(negedge clk_sys_i);
         for (int d = 0; d < NrDevices; d++)
            if (device_req_o[d] === 1'b1)
               pend.push_back('{dev: d, due: cyc + dev_lat[d],
                                data: dev_data[d] + 32'(device_addr_o[d][3:2]), err: dev_err[d]});
         @(posedge clk_sys_i);
         #1;
         cyc++;
         device_rvalid_i = '0;
         device_err_i    = '0;
         for (int d = 0; d < NrDevices; d++) device_rdata_i[d] = '0;
         for (int k = pend.size() - 1; k >= 0; k--) begin
            if (pend[k].due == cyc) begin
               device_rvalid_i[pend[k].dev] = 1'b1;
               device_err_i[pend[k].dev]    = pend[k].err;
               device_rdata_i[pend[k].dev]  = pend[k].data;
               pend.delete(k);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion by 100000, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk_sys_i);
      #2;
   endtask

   task automatic test_reset();
      host_req_i     = 2'b11;
      host_addr_i[0] = 32'h0010_0000;
      host_addr_i[1] = 32'h8000_0000;
      #1 rst_sys_ni  = 1'b0;
      @(negedge clk_sys_i);
      @(negedge clk_sys_i);
      vectors++; if (host_gnt_o !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", host_gnt_o); end
      vectors++; if (device_req_o !== 8'h00) begin miscompares++; $display("FAIL reset_dev_req: got %h want 00", device_req_o); end
      vectors++; if (host_rvalid_o !== 2'b00) begin miscompares++; $display("FAIL reset_rvalid: got %b want 00", host_rvalid_o); end
      vectors++; if (host_err_o !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b want 00", host_err_o); end
      vectors++; if (host_rdata_o[0] !== 32'h0 || host_rdata_o[1] !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h/%h want 0/0", host_rdata_o[0], host_rdata_o[1]); end
      tick();
      host_req_i = 2'b00;
      rst_sys_ni = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      dev_lat[0] = 1; dev_data[0] = 32'hDEAD_BEEF;
      host_req_i = 2'b01; host_addr_i[0] = 32'h0010_0010; host_we_i = 2'b00;
      @(negedge clk_sys_i);
      vectors++; if (host_gnt_o !== 2'b01) begin miscompares++; $display("FAIL rd_gnt: got %b want 01", host_gnt_o); end
      vectors++; if (device_req_o !== 8'h01) begin miscompares++; $display("FAIL rd_dev_req: got %h want 01", device_req_o); end
      vectors++; if (device_addr_o[0] !== 32'h0010_0010) begin miscompares++; $display("FAIL rd_dev_addr: got %h want 00100010", device_addr_o[0]); end
      tick();
      host_req_i = 2'b00;
      @(negedge clk_sys_i);
      vectors++; if (host_rvalid_o !== 2'b00) begin miscompares++; $display("FAIL rd_early_rvalid: got %b want 00", host_rvalid_o); end
      tick();
      @(negedge clk_sys_i);
      vectors++; if (host_rvalid_o !== 2'b01) begin miscompares++; $display("FAIL rd_rvalid: got %b want 01", host_rvalid_o); end
      vectors++; if (host_rdata_o[0] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_rdata: got %h want deadbeef", host_rdata_o[0]); end
      vectors++; if (host_err_o !== 2'b00) begin miscompares++; $display("FAIL rd_err: got %b want 00", host_err_o); end
      tick();
      @(negedge clk_sys_i);
      vectors++; if (host_rvalid_o !== 2'b00 || host_rdata_o[0] !== 32'h0) begin miscompares++; $display("FAIL rd_pulse: got rvalid %b rdata %h want 00 0", host_rvalid_o, host_rdata_o[0]); end
      tick();
   endtask

   task automatic test_decode_miss();
      host_req_i = 2'b10; host_addr_i[1] = 32'h4000_0000; host_we_i = 2'b10;
      host_wdata_i[1] = 32'h1234_5678;
      @(negedge clk_sys_i);
      vectors++; if (host_gnt_o !== 2'b10) begin miscompares++; $display("FAIL miss_gnt: got %b want 10", host_gnt_o); end
      vectors++; if (device_req_o !== 8'h00) begin miscompares++; $display("FAIL miss_dev_req: got %h want 00", device_req_o); end
      tick();
      host_req_i = 2'b00; host_we_i = 2'b00;
      @(negedge clk_sys_i);
      vectors++; if (host_rvalid_o !== 2'b00) begin miscompares++; $display("FAIL miss_early_rvalid: got %b want 00", host_rvalid_o); end
      tick();
      @(negedge clk_sys_i);
      vectors++; if (host_rvalid_o !== 2'b10) begin miscompares++; $display("FAIL miss_rvalid: got %b want 10", host_rvalid_o); end
      vectors++; if (host_err_o !== 2'b10) begin miscompares++; $display("FAIL miss_err: got %b want 10", host_err_o); end
      vectors++; if (host_rdata_o[1] !== 32'h0) begin miscompares++; $display("FAIL miss_rdata: got %h want 0", host_rdata_o[1]); end
      tick();
      @(negedge clk_sys_i);
      vectors++; if (host_rvalid_o !== 2'b00 || host_err_o !== 2'b00) begin miscompares++; $display("FAIL miss_pulse: got rvalid %b err %b want 00 00", host_rvalid_o, host_err_o); end
      tick();
   endtask

   task automatic test_rr_alternate();
      logic [1:0] exp_gnt;
      logic [1:0] exp_rv;
      int         h;
      dev_lat[1] = 1; dev_data[1] = 32'h1234_5600;
      host_addr_i[0] = 32'h8000_0000; host_addr_i[1] = 32'h8000_0004;
      for (int i = 0; i < 8; i++) begin
         host_req_i = (i < 6) ? 2'b11 : 2'b00;
         @(negedge clk_sys_i);
         exp_gnt = (i >= 6) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
         vectors++; if (host_gnt_o !== exp_gnt) begin miscompares++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, host_gnt_o, exp_gnt); end
         if (i < 6) begin
            vectors++; if (device_req_o !== 8'h02) begin miscompares++; $display("FAIL rr_dev_req[%0d]: got %h want 02", i, device_req_o); end
         end
         if (i >= 2) begin
            h      = (i - 2) % 2;
            exp_rv = (h == 0) ? 2'b01 : 2'b10;
            vectors++; if (host_rvalid_o !== exp_rv) begin miscompares++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, host_rvalid_o, exp_rv); end
            vectors++; if (host_rdata_o[h] !== 32'h1234_5600 + 32'(h)) begin miscompares++; $display("FAIL rr_rdata[%0d]: got %h want %h", i, host_rdata_o[h], 32'h1234_5600 + 32'(h)); end
         end else begin
            vectors++; if (host_rvalid_o !== 2'b00) begin miscompares++; $display("FAIL rr_rvalid[%0d]: got %b want 00", i, host_rvalid_o); end
         end
         tick();
      end
   endtask

   task automatic test_outstanding_limit();
      logic [1:0]  exp_gnt;
      logic [1:0]  exp_rv;
      logic [31:0] exp_rd;
      dev_lat[0] = 5; dev_data[0] = 32'hA5A5_0000;
      for (int i = 0; i < 14; i++) begin
         host_req_i     = (i <= 6) ? 2'b01 : 2'b00;
         host_addr_i[0] = 32'h0010_0000 + ((i == 0) ? 32'd0 : (i == 1) ? 32'd4 : 32'd8);
         @(negedge clk_sys_i);
         exp_gnt = (i == 0 || i == 1 || i == 6) ? 2'b01 : 2'b00;
         exp_rv  = (i == 6 || i == 7 || i == 12) ? 2'b01 : 2'b00;
         exp_rd  = (i == 6) ? 32'hA5A5_0000 : (i == 7) ? 32'hA5A5_0001 :
                   (i == 12) ? 32'hA5A5_0002 : 32'h0;
         vectors++; if (host_gnt_o !== exp_gnt) begin miscompares++; $display("FAIL lim_gnt[%0d]: got %b want %b", i, host_gnt_o, exp_gnt); end
         vectors++; if (host_rvalid_o !== exp_rv) begin miscompares++; $display("FAIL lim_rvalid[%0d]: got %b want %b", i, host_rvalid_o, exp_rv); end
         vectors++; if (host_rdata_o[0] !== exp_rd) begin miscompares++; $display("FAIL lim_rdata[%0d]: got %h want %h", i, host_rdata_o[0], exp_rd); end
         tick();
      end
   endtask

   task automatic test_device_err();
      dev_lat[4] = 2; dev_data[4] = 32'h0000_7117; dev_err[4] = 1'b1;
      host_req_i = 2'b01; host_addr_i[0] = 32'h8000_3000;
      @(negedge clk_sys_i);
      vectors++; if (host_gnt_o !== 2'b01) begin miscompares++; $display("FAIL err_gnt: got %b want 01", host_gnt_o); end
      vectors++; if (device_req_o !== 8'h10) begin miscompares++; $display("FAIL err_dev_req: got %h want 10", device_req_o); end
      tick();
      host_req_i = 2'b00;
      device_rvalid_i[2] = 1'b1;
      device_rdata_i[2]  = 32'hBADB_AD00;
      @(negedge clk_sys_i);
      vectors++; if (host_rvalid_o !== 2'b00) begin miscompares++; $display("FAIL err_early_rvalid: got %b want 00", host_rvalid_o); end
      tick();
      @(negedge clk_sys_i);
      vectors++; if (host_rvalid_o !== 2'b00) begin miscompares++; $display("FAIL stray_dropped: got %b want 00", host_rvalid_o); end
      tick();
      @(negedge clk_sys_i);
      vectors++; if (host_rvalid_o !== 2'b01) begin miscompares++; $display("FAIL err_rvalid: got %b want 01", host_rvalid_o); end
      vectors++; if (host_err_o !== 2'b01) begin miscompares++; $display("FAIL err_err: got %b want 01", host_err_o); end
      vectors++; if (host_rdata_o[0] !== 32'h0000_7117) begin miscompares++; $display("FAIL err_rdata: got %h want 00007117", host_rdata_o[0]); end
      tick();
      @(negedge clk_sys_i);
      vectors++; if (host_rvalid_o !== 2'b00 || host_err_o !== 2'b00) begin miscompares++; $display("FAIL err_pulse: got rvalid %b err %b want 00 00", host_rvalid_o, host_err_o); end
      dev_err[4] = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      dev_lat[0] = 4; dev_data[0] = 32'h0BAD_0000;
      host_req_i = 2'b11; host_addr_i[0] = 32'h0010_0000; host_addr_i[1] = 32'h0010_0004;
      @(negedge clk_sys_i);
      vectors++; if (host_gnt_o !== 2'b10) begin miscompares++; $display("FAIL rst_pre_gnt0: got %b want 10", host_gnt_o); end
      tick();
      host_req_i = 2'b01;
      @(negedge clk_sys_i);
      vectors++; if (host_gnt_o !== 2'b01) begin miscompares++; $display("FAIL rst_pre_gnt1: got %b want 01", host_gnt_o); end
      tick();
      rst_sys_ni = 1'b0;
      host_req_i = 2'b11;
      @(negedge clk_sys_i);
      vectors++; if (host_gnt_o !== 2'b00) begin miscompares++; $display("FAIL rst_mid_gnt: got %b want 00", host_gnt_o); end
      vectors++; if (device_req_o !== 8'h00) begin miscompares++; $display("FAIL rst_mid_dev_req: got %h want 00", device_req_o); end
      vectors++; if (host_rvalid_o !== 2'b00 || host_err_o !== 2'b00) begin miscompares++; $display("FAIL rst_mid_rvalid: got rvalid %b err %b want 00 00", host_rvalid_o, host_err_o); end
      tick();
      tick();
      rst_sys_ni = 1'b1;
      host_req_i = 2'b00;
      for (int i = 4; i <= 5; i++) begin
         @(negedge clk_sys_i);
         vectors++; if (host_rvalid_o !== 2'b00) begin miscompares++; $display("FAIL rst_late_rvalid[%0d]: got %b want 00", i, host_rvalid_o); end
         tick();
      end
      host_req_i = 2'b11;
      @(negedge clk_sys_i);
      vectors++; if (host_rvalid_o !== 2'b00) begin miscompares++; $display("FAIL rst_late_rvalid[6]: got %b want 00", host_rvalid_o); end
      vectors++; if (host_gnt_o !== 2'b01) begin miscompares++; $display("FAIL rst_first_gnt: got %b want 01", host_gnt_o); end
      vectors++; if (device_req_o !== 8'h01) begin miscompares++; $display("FAIL rst_first_dev_req: got %h want 01", device_req_o); end
      tick();
      host_req_i = 2'b00;
      for (int i = 7; i <= 11; i++) begin
         @(negedge clk_sys_i);
         vectors++; if (host_rvalid_o !== ((i == 11) ? 2'b01 : 2'b00)) begin miscompares++; $display("FAIL rst_post_rvalid[%0d]: got %b want %b", i, host_rvalid_o, (i == 11) ? 2'b01 : 2'b00); end
         if (i == 11) begin
            vectors++; if (host_rdata_o[0] !== 32'h0BAD_0000) begin miscompares++; $display("FAIL rst_post_rdata: got %h want 0bad0000", host_rdata_o[0]); end
         end
         tick();
      end
   endtask

   initial begin
      host_req_i = '0;
      host_we_i  = '0;
      for (int h = 0; h < NrHosts; h++) begin
         host_addr_i[h]  = '0;
         host_be_i[h]    = 4'hF;
         host_wdata_i[h] = '0;
      end
      for (int d = 0; d < NrDevices; d++) begin
         dev_lat[d]  = 1;
         dev_data[d] = '0;
         dev_err[d]  = 1'b0;
      end
      cfg_device_addr_base[0] = 32'h0010_0000; cfg_device_addr_mask[0] = 32'hFFF0_0000;
      cfg_device_addr_base[1] = 32'h8000_0000; cfg_device_addr_mask[1] = 32'hFFFF_F000;
      cfg_device_addr_base[2] = 32'h8000_1000; cfg_device_addr_mask[2] = 32'hFFFF_F000;
      cfg_device_addr_base[3] = 32'h8000_2000; cfg_device_addr_mask[3] = 32'hFFFF_F000;
      cfg_device_addr_base[4] = 32'h8000_3000; cfg_device_addr_mask[4] = 32'hFFFF_F000;
      cfg_device_addr_base[5] = 32'h8000_4000; cfg_device_addr_mask[5] = 32'hFFFF_F000;
      cfg_device_addr_base[6] = 32'h0002_0000; cfg_device_addr_mask[6] = 32'hFFFF_FC00;
      cfg_device_addr_base[7] = 32'h1A11_0000; cfg_device_addr_mask[7] = 32'hFFFF_0000;

      test_reset();
      test_single_read();
      test_decode_miss();
      test_rr_alternate();
      test_outstanding_limit();
      test_device_err();
      test_reset_mid();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
